mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  N-port round-robin arbiter/sequencer between per-core memory interface units and one shared memory port.
//  Generalises the fixed 4-request memory front end (one port used, three tied off) to N_PORTS live requesters.
//  Adds per-request read/write select, bounded-latency timeout with error response, and grant tracking.
//  Sits between the memInerf instances of each ALU/IU core and the single-ported SRAM/memory subsystem.
// PARAMETERS
//  N_PORTS  4   number of requesting cores (>=2)
//  ADDR_W   14  memory address width
//  WDATA_W  16  write data width (result word)
//  RDATA_W  8   read data width (operand byte)
//  TIMEOUT  15  max cycles waiting for mem_ack before error response (>=1)
//  CNT_W    16  width of per-port grant counters (see CONFIGURATION)
// PORTS
//  clk         in   1                  clock; all logic on posedge
//  reset       in   1                  synchronous, active-high reset
//  port_req    in   N_PORTS            level request per port; held until that port's port_resp
//  port_we     in   N_PORTS            1=write, 0=read; stable while req high
//  port_addr   in   N_PORTS*ADDR_W     packed, port i at [i*ADDR_W +: ADDR_W]
//  port_wdata  in   N_PORTS*WDATA_W    packed write data
//  port_resp   out  N_PORTS            one-cycle completion pulse to granted port only
//  port_err    out  1                  valid with port_resp; 1 = timed out, rdata invalid
//  port_rdata  out  RDATA_W            read data, valid with port_resp (0 on writes/errors)
//  mem_re      out  1                  one-cycle read strobe
//  mem_we      out  1                  one-cycle write strobe
//  mem_addr    out  ADDR_W             registered address, stable ISSUE..RESP
//  mem_wdata   out  WDATA_W            registered write data, stable ISSUE..RESP
//  mem_rdata   in   RDATA_W            captured on the cycle mem_ack is high
//  mem_ack     in   1                  memory completion pulse
//  busy        out  1                  high in any state except IDLE
//  grant_id    out  $clog2(N_PORTS)    index of current/last granted port
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; rr pointer=N_PORTS-1 (so port 0 has first priority).
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE; WAIT skipped if mem_ack arrives in ISSUE.
//  IDLE: if any port_req, pick first requester searching ptr+1, ptr+2.. wrapping mod N_PORTS;
//   register grant_id, addr, wdata, we; ptr<=grant; ->ISSUE. No request: stay IDLE.
//  ISSUE: exactly one of mem_re/mem_we high for this cycle only; timeout counter cleared.
//   mem_ack here -> RESP, else ->WAIT.
//  WAIT: counter++ per cycle; mem_ack -> RESP with err=0; counter==TIMEOUT without ack -> RESP err=1.
//  RESP: port_resp[grant_id]=1 for one cycle; rdata=captured byte (read, no error) else 0; ->IDLE.
//  Latency: req seen in IDLE at cycle 0 -> resp at cycle 2 min, cycle 3+TIMEOUT max.
//  Requester must drop req on the edge it samples resp; the mandatory IDLE cycle prevents re-grant.
//  Req dropped mid-transaction: transaction still completes, resp still pulsed (ignored by port).
//  mem_ack in IDLE or RESP: ignored. mem_ack on the same cycle as timeout: ack wins, err=0.
//  All ports requesting continuously: grants strictly rotate 0,1,..,N_PORTS-1,0; no starvation.
//  Reset mid-transaction: immediate return to reset state; no resp issued for the aborted request.
//  Exactly one bit of port_resp is ever high; mem_re & mem_we never both high.
// CONFIGURATION
//  MEMARB_PERF_CNT_EN defined: extra output grant_cnt [N_PORTS*CNT_W]; port i counter
//   +1 on each IDLE->ISSUE grant to i, saturates at all-ones, cleared by reset.
//  Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  memarb_pkg: arb_state_t enum {IDLE,ISSUE,WAIT,RESP}; MEMARB_CNT_W default constant.
//  Sub-module rr_arbiter #(N): combinational req+ptr -> one-hot grant + index; FSM/datapath in this module.
//  Instantiated inside the multi-core successor of alumifiu_dut, replacing the tied-off request ports.
// TESTING
//  Single read: port 2 req, we=0, addr=14'h0123, ack 1 cycle after ISSUE with rdata=8'hA5
//   -> mem_re pulse, addr 0x0123, port_resp=4'b0100, rdata=8'hA5, err=0.
//  Write: port 0 we=1, wdata=16'hBEEF -> mem_we single pulse, mem_wdata=16'hBEEF, resp[0], rdata=0.
//  Fairness: all 4 req held (re-raised after each resp), ack immediate -> grant_id 0,1,2,3,0,1 per grant.
//  Timeout: TIMEOUT=15, no ack -> resp exactly 18 cycles after req sampled, err=1, rdata=0; next grant proceeds.
//  Reset during WAIT: reset high 1 cycle -> outputs 0, no resp; new req 2 cycles later served normally.
//  MEMARB_PERF_CNT_EN: 5 grants to port 1, 2 to port 3 -> grant_cnt port1=5, port3=2, others 0.

Source files
------------

// File: rtl/memarb_pkg.sv
// Shared types for the N-port round-robin memory port arbiter.
package memarb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int MEMARB_CNT_W = 16;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Combinational round-robin pick: first requester after ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port round-robin sequencer onto one shared memory port with timeout/error response.
// Optional per-port grant counters are built when MEMARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 14,
  parameter int WDATA_W = 16,
  parameter int RDATA_W = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = MEMARB_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_PORTS-1:0]           port_req,
  input  logic [N_PORTS-1:0]           port_we,
  input  logic [N_PORTS*ADDR_W-1:0]    port_addr,
  input  logic [N_PORTS*WDATA_W-1:0]   port_wdata,
  output logic [N_PORTS-1:0]           port_resp,
  output logic                         port_err,
  output logic [RDATA_W-1:0]           port_rdata,
  output logic                         mem_re,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [WDATA_W-1:0]           mem_wdata,
  input  logic [RDATA_W-1:0]           mem_rdata,
  input  logic                         mem_ack,
  output logic                         busy,
  output logic [$clog2(N_PORTS)-1:0]   grant_id
`ifdef MEMARB_PERF_CNT_EN
  ,
  output logic [N_PORTS*CNT_W-1:0]     grant_cnt
`endif
);

  localparam int ID_W = $clog2(N_PORTS);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  arb_state_t state, state_nx;

  logic [N_PORTS-1:0][ADDR_W-1:0]  addr_v;
  logic [N_PORTS-1:0][WDATA_W-1:0] wdata_v;
  logic [ID_W-1:0]                 ptr, arb_idx;
  logic [N_PORTS-1:0]              arb_oh, grant_oh;
  logic                            arb_any;
  logic                            we_r, err_r;
  logic [RDATA_W-1:0]              rdata_r;
  logic [TO_W-1:0]                 to_cnt;
  logic                            timeout_hit;

  assign addr_v      = port_addr;
  assign wdata_v     = port_wdata;
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT));

  rr_arbiter #(.N(N_PORTS)) u_rr (
    .req       (port_req),
    .ptr       (ptr),
    .grant     (arb_oh),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arb_any) state_nx = ISSUE;
      ISSUE:   state_nx = mem_ack ? RESP : WAIT;
      WAIT:    if (mem_ack || timeout_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    busy       = (state != IDLE);
    port_resp  = '0;
    port_err   = 1'b0;
    port_rdata = '0;
    case (state)
      ISSUE: begin
        mem_re = !we_r;
        mem_we = we_r;
      end
      RESP: begin
        port_resp  = grant_oh;
        port_err   = err_r;
        port_rdata = rdata_r;
      end
      default: ;
    endcase
  end

  // Grant capture, ack/timeout resolution; an ack on the timeout cycle takes precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= ID_W'(N_PORTS - 1);
      grant_id  <= '0;
      grant_oh  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_r      <= 1'b0;
      err_r     <= 1'b0;
      rdata_r   <= '0;
      to_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            ptr       <= arb_idx;
            grant_id  <= arb_idx;
            grant_oh  <= arb_oh;
            mem_addr  <= addr_v[arb_idx];
            mem_wdata <= wdata_v[arb_idx];
            we_r      <= port_we[arb_idx];
          end
        end
        ISSUE: begin
          to_cnt <= '0;
          if (mem_ack) begin
            err_r   <= 1'b0;
            rdata_r <= we_r ? '0 : mem_rdata;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            err_r   <= 1'b0;
            rdata_r <= we_r ? '0 : mem_rdata;
          end else if (timeout_hit) begin
            err_r   <= 1'b1;
            rdata_r <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEMARB_PERF_CNT_EN
  logic [N_PORTS-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state == IDLE && arb_any && cnt_q[arb_idx] != {CNT_W{1'b1}}) begin
      cnt_q[arb_idx] <= cnt_q[arb_idx] + 1'b1;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level timing model checked every cycle plus directed literal checks.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int WW = 16;
  localparam int RW = 8;
  localparam int TO = 15;
  localparam int CW = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [N-1:0]           port_req, port_we;
  logic [N-1:0][AW-1:0]   addr_a;
  logic [N-1:0][WW-1:0]   wdata_a;
  logic [N-1:0]           port_resp;
  logic                   port_err;
  logic [RW-1:0]          port_rdata;
  logic                   mem_re, mem_we;
  logic [AW-1:0]          mem_addr;
  logic [WW-1:0]          mem_wdata;
  logic [RW-1:0]          mem_rdata;
  logic                   mem_ack;
  logic                   busy;
  logic [IW-1:0]          grant_id;
`ifdef MEMARB_PERF_CNT_EN
  logic [N-1:0][CW-1:0]   cnt_a;
`endif

  mem_port_arbiter #(
    .N_PORTS(N), .ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .port_req   (port_req),
    .port_we    (port_we),
    .port_addr  (addr_a),
    .port_wdata (wdata_a),
    .port_resp  (port_resp),
    .port_err   (port_err),
    .port_rdata (port_rdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .grant_id   (grant_id)
`ifdef MEMARB_PERF_CNT_EN
    ,
    .grant_cnt  (cnt_a)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: one outstanding transaction described by its issue cycle and resolved response cycle.
  bit            m_valid = 0, m_active = 0, m_we = 0, m_err = 0;
  int            m_issue = 0, m_resp_cyc = -1, m_port = 0, m_last = N - 1, m_gid = 0;
  logic [AW-1:0] m_addr = '0;
  logic [WW-1:0] m_wdata = '0;
  logic [RW-1:0] m_rdata = '0;
  int            m_cnt [N];

  bit            hold = 0, spurious = 0;
  int            ack_delay = 0, pend = 0;
  logic [RW-1:0] rd_val = '0;

  logic [N-1:0]  r_resp;
  logic          r_err, r_re, r_we, r_busy;
  logic [RW-1:0] r_rdata;
  logic [AW-1:0] r_addr;
  logic [WW-1:0] r_wdata;
  logic [IW-1:0] r_gid;
  int            r_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_compare();
    bit           in_resp;
    logic [N-1:0] e_resp;
    if (!m_valid) return;
    in_resp = m_active && (cyc == m_resp_cyc);
    e_resp  = in_resp ? (N'(1) << m_port) : '0;
    chk("busy", busy, m_active);
    chk("mem_re", mem_re, m_active && cyc == m_issue && !m_we);
    chk("mem_we", mem_we, m_active && cyc == m_issue && m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("grant_id", grant_id, m_gid);
    chk("port_resp", port_resp, e_resp);
    chk("port_err", port_err, in_resp && m_err);
    chk("port_rdata", port_rdata, in_resp ? m_rdata : '0);
`ifdef MEMARB_PERF_CNT_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", cnt_a[IW'(i)], m_cnt[i]);
`endif
  endtask

  task automatic model_advance();
    bit found;
    int p;
    if (reset) begin
      m_valid = 1; m_active = 0; m_last = N - 1; m_gid = 0; m_resp_cyc = -1;
      m_addr = '0; m_wdata = '0; m_we = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    if (!m_valid) return;
    if (!m_active) begin
      found = 0; p = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && port_req[IW'((m_last + k) % N)]) begin
          found = 1;
          p = (m_last + k) % N;
        end
      end
      if (found) begin
        m_active = 1; m_issue = cyc + 1; m_port = p; m_resp_cyc = -1;
        m_we = port_we[IW'(p)]; m_addr = addr_a[IW'(p)]; m_wdata = wdata_a[IW'(p)];
        m_last = p; m_gid = p;
        if (m_cnt[p] < (1 << CW) - 1) m_cnt[p]++;
      end
    end else if (cyc == m_resp_cyc) begin
      m_active = 0;
    end else if (m_resp_cyc < 0) begin
      if (mem_ack) begin
        m_resp_cyc = cyc + 1; m_err = 0; m_rdata = m_we ? '0 : mem_rdata;
      end else if (cyc == m_issue + 1 + TO) begin
        m_resp_cyc = cyc + 1; m_err = 1; m_rdata = '0;
      end
    end
  endtask

  // One clock: check/capture at negedge, then drive requester and memory responder after posedge.
  task automatic step();
    @(negedge clk);
    model_compare();
    r_resp = port_resp; r_err = port_err; r_rdata = port_rdata; r_re = mem_re; r_we = mem_we;
    r_addr = mem_addr; r_wdata = mem_wdata; r_gid = grant_id; r_busy = busy; r_cyc = cyc;
    model_advance();
    cyc++;
    @(posedge clk);
    #1;
    if (!hold) port_req = port_req & ~r_resp;
    mem_ack = 1'b0;
    mem_rdata = '0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin mem_ack = 1'b1; mem_rdata = rd_val; end
    end
    if (mem_re || mem_we) begin
      if (ack_delay == 0) begin mem_ack = 1'b1; mem_rdata = rd_val; end
      else if (ack_delay > 0) pend = ack_delay;
    end
    if (spurious && !busy) begin mem_ack = 1'b1; mem_rdata = 8'hEE; end
  endtask

  task automatic issue(input int p, input bit we, input logic [AW-1:0] a, input logic [WW-1:0] d);
    port_we[IW'(p)] = we;
    addr_a[IW'(p)]  = a;
    wdata_a[IW'(p)] = d;
    port_req[IW'(p)] = 1'b1;
  endtask

  task automatic wait_resp(input string tag, input int budget, output int nre, output int nwe,
                           output logic [AW-1:0] sa, output logic [WW-1:0] sw);
    bit got;
    got = 0; nre = 0; nwe = 0; sa = '0; sw = '0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (r_re) begin nre++; sa = r_addr; end
      if (r_we) begin nwe++; sw = r_wdata; end
      if (r_resp != '0) got = 1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s: no port_resp within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int            c0, nre, nwe, nresp;
    logic [AW-1:0] sa;
    logic [WW-1:0] sw;
    reset = 1'b1; port_req = '0; port_we = '0; addr_a = '0; wdata_a = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_busy", r_busy, 1'b0);
    chk("rst_resp", r_resp, 4'b0000);
    chk("rst_gid", r_gid, 2'd0);
    chk("rst_addr", r_addr, 14'h0);

    // Single read on port 2, ack one cycle after ISSUE
    ack_delay = 1; rd_val = 8'hA5; c0 = cyc;
    issue(2, 1'b0, 14'h0123, 16'h0000);
    wait_resp("rd", 40, nre, nwe, sa, sw);
    chk("rd_resp", r_resp, 4'b0100);
    chk("rd_rdata", r_rdata, 8'hA5);
    chk("rd_err", r_err, 1'b0);
    chk("rd_lat", r_cyc - c0, 3);
    chk("rd_re_cnt", nre, 1);
    chk("rd_we_cnt", nwe, 0);
    chk("rd_addr", sa, 14'h0123);
    step();

    // Write on port 0, ack in ISSUE
    ack_delay = 0; c0 = cyc;
    issue(0, 1'b1, 14'h0042, 16'hBEEF);
    wait_resp("wr", 40, nre, nwe, sa, sw);
    chk("wr_resp", r_resp, 4'b0001);
    chk("wr_rdata", r_rdata, 8'h00);
    chk("wr_err", r_err, 1'b0);
    chk("wr_lat", r_cyc - c0, 2);
    chk("wr_we_cnt", nwe, 1);
    chk("wr_re_cnt", nre, 0);
    chk("wr_wdata", sw, 16'hBEEF);
    step();

    // Fairness from reset: all four held
    reset = 1'b1; step(); reset = 1'b0; step();
    hold = 1; ack_delay = 0; rd_val = 8'h10;
    for (int p = 0; p < N; p++) issue(p, 1'b0, AW'(p * 16), 16'h0);
    for (int g = 0; g < 6; g++) begin
      wait_resp("fair", 20, nre, nwe, sa, sw);
      chk("fair_gid", r_gid, g % N);
      chk("fair_resp", r_resp, 4'b0001 << (g % N));
    end
    hold = 0; port_req = '0;
    repeat (4) step();

    // Timeout with no ack; requester drops req mid-transaction
    ack_delay = -1; c0 = cyc;
    issue(3, 1'b0, 14'h3FFF, 16'h0);
    step(); step();
    port_req[3] = 1'b0;
    wait_resp("to", 40, nre, nwe, sa, sw);
    chk("to_resp", r_resp, 4'b1000);
    chk("to_err", r_err, 1'b1);
    chk("to_rdata", r_rdata, 8'h00);
    chk("to_lat", r_cyc - c0, 18);
    ack_delay = 2; rd_val = 8'h5A; c0 = cyc;
    issue(1, 1'b0, 14'h0001, 16'h0);
    wait_resp("after_to", 40, nre, nwe, sa, sw);
    chk("ato_resp", r_resp, 4'b0010);
    chk("ato_err", r_err, 1'b0);
    chk("ato_rdata", r_rdata, 8'h5A);
    chk("ato_lat", r_cyc - c0, 4);
    step();

    // Ack on the timeout cycle wins
    ack_delay = 1 + TO; rd_val = 8'h3C; c0 = cyc;
    issue(0, 1'b0, 14'h0200, 16'h0);
    wait_resp("ack_at_to", 40, nre, nwe, sa, sw);
    chk("aat_err", r_err, 1'b0);
    chk("aat_rdata", r_rdata, 8'h3C);
    chk("aat_lat", r_cyc - c0, 18);
    step();

    // Reset during WAIT aborts without a response
    ack_delay = -1; c0 = cyc;
    issue(1, 1'b0, 14'h0AAA, 16'h0);
    repeat (4) step();
    reset = 1'b1; step(); reset = 1'b0; pend = 0; port_req = '0;
    step();
    chk("rw_busy", r_busy, 1'b0);
    chk("rw_addr", r_addr, 14'h0);
    nresp = (r_resp != '0) ? 1 : 0;
    step();
    if (r_resp != '0) nresp++;
    chk("rw_no_resp", nresp, 0);
    ack_delay = 0; rd_val = 8'h77; c0 = cyc;
    issue(2, 1'b0, 14'h0155, 16'h0);
    wait_resp("after_rst", 40, nre, nwe, sa, sw);
    chk("arst_resp", r_resp, 4'b0100);
    chk("arst_rdata", r_rdata, 8'h77);
    chk("arst_lat", r_cyc - c0, 2);
    step();

    // Stray acks while idle are ignored
    spurious = 1; ack_delay = 3; rd_val = 8'h11; c0 = cyc;
    issue(3, 1'b0, 14'h0300, 16'h0);
    wait_resp("stray", 40, nre, nwe, sa, sw);
    chk("stray_rdata", r_rdata, 8'h11);
    chk("stray_lat", r_cyc - c0, 5);
    step(); step();
    spurious = 0;
    step();

`ifdef MEMARB_PERF_CNT_EN
    reset = 1'b1; step(); reset = 1'b0; step();
    ack_delay = 0;
    for (int i = 0; i < 7; i++) begin
      issue((i < 5) ? 1 : 3, 1'b1, 14'h0010, 16'h1234);
      wait_resp("perf", 20, nre, nwe, sa, sw);
      step();
    end
    chk("cnt_p0", cnt_a[0], 16'd0);
    chk("cnt_p1", cnt_a[1], 16'd5);
    chk("cnt_p2", cnt_a[2], 16'd0);
    chk("cnt_p3", cnt_a[3], 16'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
